if_fetch_unit: RTL
==================

# if_fetch_unit

Instruction-fetch stage of the pipelined CPU: owns the program counter, runs a request/acknowledge handshake with instruction memory, and presents one instruction plus its PC+4 per cycle to the IF/ID pipeline register. It applies branch/jump redirects, honours hazard and data-cache stalls, and buffers a fetched instruction while the pipeline is frozen. When it has nothing valid to offer, it drives a bubble of all-zero instruction and all-zero PC.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- clk_i  in  1  pipeline clock; all state changes on posedge.
- rst_i  in  1  reset, asynchronous, active-low.
- start_i  in  1  level; fetching begins at the first posedge where it is 1.
- Hazard_stall_i  in  1  load-use stall from the hazard unit; freezes fetch advance.
- CacheStall_i  in  1  data-cache miss stall; freezes fetch advance.
- branch_i  in  1  taken-branch redirect, resolved in ID.
- branch_target_i  in  32  branch target address.
- jump_i  in  1  jump redirect, resolved in ID.
- jump_target_i  in  32  jump target address.
- imem_req_o  out  1  fetch request to instruction memory.
- imem_addr_o  out  32  word-aligned fetch address, equal to pc_q.
- imem_ack_i  in  1  memory has valid data this cycle; sampled only while imem_req_o=1.
- imem_data_i  in  32  instruction word, valid when imem_ack_i=1.
- pc_o  out  32  current PC, pc_q.
- addedPC_o  out  32  PC+4 of the presented instruction; 0 when no instruction is presented.
- inst_o  out  32  presented instruction; 0 (NOP bubble) when none is presented.

## Operation
- State: pc_q, FSM {IDLE, FETCH, READY}, inst_buf[31:0], kill, redir_pc[31:0].
- Definitions:
  - hit = (state==FETCH) & imem_ack_i & ~kill.
  - valid = (state==READY) | hit.
  - frz = Hazard_stall_i | CacheStall_i.
  - adv = valid & ~frz.
  - redir = (branch_i | jump_i) & ~frz.
- Combinational outputs:
  - When valid: inst_o is inst_buf in READY and imem_data_i on a hit.
  - When valid: addedPC_o = pc_q+4.
  - Otherwise inst_o and addedPC_o are both 0.
  - imem_req_o = (state==FETCH).
- IDLE: start_i=1 → FETCH. No request is issued in IDLE.
- FETCH, in priority order:
  - If redir and imem_ack_i: discard the data, set pc_q to the target, stay in FETCH.
  - If redir and no ack: address stays held. Set kill=1 and redir_pc to the target.
  - If kill and imem_ack_i: discard the data, set pc_q to redir_pc, clear kill, stay in FETCH.
  - If hit and adv: pc_q += 4, stay in FETCH. Back-to-back fetches give a throughput of 1 instruction per cycle.
  - If hit and frz: inst_buf takes imem_data_i, go to READY.
- READY:
  - If redir: pc_q takes the target, go to FETCH.
  - If adv: pc_q += 4, go to FETCH.
  - If frz: hold.
- Redirect target: branch_i has priority over jump_i. Target bits [1:0] are forced to 0.
- A redirect arriving while frz=1 is ignored; the ID stage re-asserts it after the stall.
- A second redirect while kill=1 overwrites redir_pc.
- Arithmetic: PC+4 wraps modulo 2^32, so 32'hFFFF_FFFC → 0.
- start_i falling after the first start has no effect.

## Timing
- Reset: async assertion forces the following values immediately:
  - state=IDLE, pc_q=RESET_PC, kill=0, inst_buf=0.
  - imem_req_o=0, inst_o=0, addedPC_o=0.
  - pc_o=RESET_PC.
- Reset mid-request drops imem_req_o in the same cycle; a late ack is ignored.
- Zero-wait memory (ack in the same cycle as req): the instruction reaches inst_o in that cycle and IF/ID captures it at the next posedge.
- N-wait memory: inst_o carries bubbles for N cycles.
- imem_addr_o is stable from the rising of req until the ack cycle, including during kill.
- Stall release from READY: the buffered instruction is consumed at the first posedge with frz=0.

## Test plan
- Zero-wait, no stalls: RESET_PC=0, start_i=1 → inst_o follows mem[0],mem[4],mem[8] on consecutive cycles, with addedPC_o=4,8,12.
- 2-wait memory: each instruction is preceded by 2 bubble cycles (inst_o=0, addedPC_o=0). imem_addr_o is held during the wait.
- Hazard_stall_i=1 for 3 cycles on an ack cycle: the instruction is held in READY. inst_o repeats the same word for 3 cycles, then pc_q advances by 4.
- Redirects:
  - branch_i=1 with target 0x40 while waiting on address 0x10: the 0x10 data is discarded and the next request goes to 0x40.
  - branch_i and jump_i both 1: the fetch goes to branch_target_i.
  - A redirect while CacheStall_i=1 is ignored.
- PC 0xFFFFFFFC fetched with adv → next imem_addr_o=0.
- rst_i pulled low mid-FETCH → imem_req_o=0 and outputs 0 immediately. After release, fetching restarts at RESET_PC once start_i=1.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, handshakes with instruction memory and
// presents one instruction plus PC+4 per cycle, buffering it across pipeline freezes.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        Hazard_stall_i,
  input  logic        CacheStall_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] pc_o,
  output logic [31:0] addedPC_o,
  output logic [31:0] inst_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    READY = 2'd2
  } state_t;

  state_t      state_r;
  logic [31:0] pc_r;
  logic [31:0] inst_buf_r;
  logic        kill_r;
  logic [31:0] redir_pc_r;

  logic        hit_s;
  logic        valid_s;
  logic        frz_s;
  logic        adv_s;
  logic        redir_s;
  logic [31:0] redir_tgt_s;
  logic [31:0] pc_inc_s;

  // Handshake qualifiers and redirect target selection
  always_comb begin
    hit_s    = (state_r == FETCH) & imem_ack_i & ~kill_r;
    valid_s  = (state_r == READY) | hit_s;
    frz_s    = Hazard_stall_i | CacheStall_i;
    adv_s    = valid_s & ~frz_s;
    redir_s  = (branch_i | jump_i) & ~frz_s;
    pc_inc_s = pc_r + 32'd4;
    if (branch_i) begin
      redir_tgt_s = {branch_target_i[31:2], 2'b00};
    end else begin
      redir_tgt_s = {jump_target_i[31:2], 2'b00};
    end
  end

  // Presented instruction and PC+4, bubble of zeros when nothing is valid
  always_comb begin
    inst_o    = 32'h0000_0000;
    addedPC_o = 32'h0000_0000;
    if (valid_s) begin
      addedPC_o = pc_inc_s;
      if (state_r == READY) begin
        inst_o = inst_buf_r;
      end else begin
        inst_o = imem_data_i;
      end
    end else begin
      inst_o    = 32'h0000_0000;
      addedPC_o = 32'h0000_0000;
    end
  end

  assign imem_req_o  = (state_r == FETCH);
  assign imem_addr_o = pc_r;
  assign pc_o        = pc_r;

  // Fetch FSM, PC, instruction buffer and pending-redirect bookkeeping
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r    <= IDLE;
      pc_r       <= RESET_PC;
      inst_buf_r <= 32'h0000_0000;
      kill_r     <= 1'b0;
      redir_pc_r <= 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_i) begin
            state_r <= FETCH;
          end
        end
        FETCH: begin
          // An outstanding request must complete before the address may move
          if (redir_s && imem_ack_i) begin
            pc_r   <= redir_tgt_s;
            kill_r <= 1'b0;
          end else if (redir_s) begin
            kill_r     <= 1'b1;
            redir_pc_r <= redir_tgt_s;
          end else if (kill_r && imem_ack_i) begin
            pc_r   <= redir_pc_r;
            kill_r <= 1'b0;
          end else if (hit_s && adv_s) begin
            pc_r <= pc_inc_s;
          end else if (hit_s && frz_s) begin
            inst_buf_r <= imem_data_i;
            state_r    <= READY;
          end
        end
        READY: begin
          if (redir_s) begin
            pc_r    <= redir_tgt_s;
            state_r <= FETCH;
          end else if (adv_s) begin
            pc_r    <= pc_inc_s;
            state_r <= FETCH;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
